// File: rtl/button_press_conditioner_if.sv
// Pushbutton inputs and conditioned press-event outputs of button_press_conditioner.
interface button_press_conditioner_if;
    logic       button1;
    logic       button2;
    logic       button3;
    logic       button4;
    logic       press_valid;
    logic [1:0] press_code;
    logic       any_down;
    logic       multi_press;

    modport master (
        output button1, button2, button3, button4,
        input  press_valid, press_code, any_down, multi_press
    );

    modport slave (
        input  button1, button2, button3, button4,
        output press_valid, press_code, any_down, multi_press
    );
endinterface

// File: rtl/button_press_conditioner.sv
// Four-button synchronizer + debouncer + press-event FSM (single accepted press per hold).
// Define BTN_ACTIVE_LOW_EN for board keys that read low when pressed.
module button_press_conditioner #(
    parameter int unsigned DB_CYCLES = 250000,
    parameter int unsigned CNT_W     = 18
) (
    input  logic                         clk,
    input  logic                         rst,
    button_press_conditioner_if.slave    bus
);

    localparam int unsigned NB = 4;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

`ifdef BTN_ACTIVE_LOW_EN
    localparam logic SYNC_RST = 1'b1;
`else
    localparam logic SYNC_RST = 1'b0;
`endif

    typedef enum logic {IDLE, HELD} state_t;

    logic [NB-1:0]            raw;
    logic [NB-1:0]            sync1_q, sync2_q;
    logic [NB-1:0]            level;
    logic [NB-1:0]            db_q, db_d;
    logic [NB-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [NB-1:0]            db_prev_q;
    logic [NB-1:0]            rise_c;
    logic [1:0]               first_c;
    logic                     multi_rise_c;

    state_t     state_q;
    logic       press_valid_q;
    logic [1:0] press_code_q;
    logic       any_down_q;
    logic       multi_press_q;

    assign raw = {bus.button4, bus.button3, bus.button2, bus.button1};

    // Two-flop synchronizer per button
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= {NB{SYNC_RST}};
            sync2_q <= {NB{SYNC_RST}};
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
        end
    end

`ifdef BTN_ACTIVE_LOW_EN
    assign level = ~sync2_q;
`else
    assign level = sync2_q;
`endif

    // Counter runs only while the level disagrees; toggle and clear on the last count
    always_comb begin
        db_d  = db_q;
        cnt_d = '0;
        for (int i = 0; i < int'(NB); i++) begin
            if (level[i] != db_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    db_d[i] = ~db_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            db_q  <= '0;
            cnt_q <= '0;
        end else begin
            db_q  <= db_d;
            cnt_q <= cnt_d;
        end
    end

    assign rise_c       = db_q & ~db_prev_q;
    assign multi_rise_c = (rise_c & (rise_c - 1'b1)) != '0;

    // Lowest-index rising button wins
    always_comb begin
        first_c = '0;
        for (int i = int'(NB) - 1; i >= 0; i--) begin
            if (rise_c[i]) begin
                first_c = 2'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            db_prev_q     <= '0;
            press_valid_q <= 1'b0;
            press_code_q  <= '0;
            any_down_q    <= 1'b0;
            multi_press_q <= 1'b0;
        end else begin
            db_prev_q     <= db_q;
            any_down_q    <= |db_q;
            press_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (|rise_c) begin
                        state_q       <= HELD;
                        press_valid_q <= 1'b1;
                        press_code_q  <= first_c;
                        multi_press_q <= multi_rise_c;
                    end
                end
                HELD: begin
                    if (|rise_c) begin
                        multi_press_q <= 1'b1;
                    end
                    if (db_q == '0) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.press_valid = press_valid_q;
    assign bus.press_code  = press_code_q;
    assign bus.any_down    = any_down_q;
    assign bus.multi_press = multi_press_q;

endmodule
